// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI initiator: FSM encoding, command R/W
// encoding and the transfer bit-counter sizing.
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic CMD_READ  = 1'b1;
    localparam logic CMD_WRITE = 1'b0;

    localparam int             BIT_CNT_W    = 5;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = 5'd16;

endpackage

// File: rtl/spi_master_if.sv
// Host request handshake plus SPI pin bundle; master is the initiator's view,
// slave is the view of whatever sits around it (host and SPI target).
interface spi_master_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  sclk_pin;
    logic                  cs_pin;
    logic                  mosi_pin;
    logic                  miso_pin;

    modport master (
        input  start, rw, addr, wdata, miso_pin,
        output busy, done, rdata, sclk_pin, cs_pin, mosi_pin
    );

    modport slave (
        output start, rw, addr, wdata, miso_pin,
        input  busy, done, rdata, sclk_pin, cs_pin, mosi_pin
    );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period divider: one tick every CLKDIV enabled cycles, alternating
// between rise_tick and fall_tick; held cleared while disabled.
module spi_clk_div #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int CNT_W = $clog2(CLKDIV);

    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic             tick;

    assign tick      = en && (cnt == CNT_W'(CLKDIV - 1));
    assign rise_tick = tick && !phase;
    assign fall_tick = tick && phase;

    always_ff @(posedge clk) begin
        if (!reset_n || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: 8-bit {addr, rw} command then 8 data bits, MSB first.
// Optional macro SPI_MASTER_MISO_SYNC_EN adds a 2-flop MISO synchronizer.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLKDIV     = 4,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input logic         clk,
    input logic         reset_n,
    spi_master_if.master bus
);
    localparam int CMD_W   = ADDR_WIDTH + 1;
    localparam int FRAME_W = CMD_W + DATA_WIDTH;

    if (CLKDIV < 4) begin : g_clkdiv_check
        $error("spi_master: CLKDIV must be >= 4");
    end
    if (FRAME_W != int'(BIT_CNT_LAST)) begin : g_frame_check
        $error("spi_master: command plus data must total BIT_CNT_LAST bits");
    end

    state_t                 state, state_next;
    logic                   load, finish;
    logic                   rise_tick, fall_tick, last_fall;
    logic [FRAME_W-1:0]     frame, tx_sh;
    logic [DATA_WIDTH-1:0]  rx_sh;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   rw_q;
    logic                   sample_now, sample, miso_s;

    assign frame     = {bus.addr, bus.rw, bus.wdata};
    assign last_fall = fall_tick && (bit_cnt == BIT_CNT_LAST - 1'b1);
    assign bus.busy  = (state != ST_IDLE);

    spi_clk_div #(.CLKDIV(CLKDIV)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (state != ST_IDLE),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            ST_IDLE: if (bus.start) begin
                load       = 1'b1;
                state_next = ST_SETUP;
            end
            ST_SETUP: if (rise_tick) state_next = ST_SHIFT;
            ST_SHIFT: if (last_fall) state_next = ST_HOLD;
            ST_HOLD: if (rise_tick || fall_tick) begin
                finish     = 1'b1;
                state_next = ST_GAP;
            end
            ST_GAP: if (rise_tick || fall_tick) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Read data bits are captured on sclk rises once the command byte is out.
    assign sample_now = (state == ST_SHIFT) && rise_tick && (rw_q == CMD_READ)
                        && (bit_cnt >= BIT_CNT_W'(CMD_W));

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic miso_p1, miso_p2, sample_p1;

    always_ff @(posedge clk) begin
        miso_p1 <= bus.miso_pin;
        miso_p2 <= miso_p1;
    end

    // Capture one cycle after the rise tick, giving the synchronizer its slack.
    always_ff @(posedge clk) begin
        if (!reset_n) sample_p1 <= 1'b0;
        else          sample_p1 <= sample_now;
    end

    assign miso_s = miso_p2;
    assign sample = sample_p1;
`else
    assign miso_s = bus.miso_pin;
    assign sample = sample_now;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.cs_pin   <= 1'b1;
            bus.sclk_pin <= 1'b0;
            bus.mosi_pin <= 1'b0;
            bus.done     <= 1'b0;
            bus.rdata    <= '0;
            bit_cnt      <= '0;
        end else begin
            bus.done <= finish;
            if (load) begin
                bus.cs_pin   <= 1'b0;
                bus.mosi_pin <= frame[FRAME_W-1];
                bit_cnt      <= '0;
            end
            if ((state == ST_SETUP || state == ST_SHIFT) && rise_tick)
                bus.sclk_pin <= 1'b1;
            if (state == ST_SHIFT && fall_tick) begin
                bus.sclk_pin <= 1'b0;
                bit_cnt      <= bit_cnt + 1'b1;
                bus.mosi_pin <= (rw_q == CMD_READ && bit_cnt >= BIT_CNT_W'(CMD_W - 1))
                                ? 1'b0 : tx_sh[FRAME_W-1];
            end
            if (finish) begin
                bus.cs_pin <= 1'b1;
                if (rw_q == CMD_READ) bus.rdata <= rx_sh;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            tx_sh <= {frame[FRAME_W-2:0], 1'b0};
            rw_q  <= bus.rw;
        end else if (state == ST_SHIFT && fall_tick) begin
            tx_sh <= tx_sh << 1;
        end
        if (sample) rx_sh <= {rx_sh[DATA_WIDTH-2:0], miso_s};
    end
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes expected frames, a negedge
// monitor pops and checks them at each done pulse; a mode-0 slave drives MISO.
module tb_spi_master;
    localparam int CLKDIV = 4;

    typedef struct {
        logic [15:0] frame;
        logic        is_read;
        logic [7:0]  rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus();

    spi_master #(.CLKDIV(CLKDIV), .ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    logic       b2b_chk = 1'b0;
    logic [7:0] slave_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Mode-0 slave: after data-phase falls 8..15 present the next read bit.
    initial begin
        bus.miso_pin = 1'b0;
        forever begin
            @(negedge bus.cs_pin);
            bus.miso_pin = 1'b0;
            for (int k = 1; k <= 15; k++) begin
                @(negedge bus.sclk_pin or posedge bus.cs_pin);
                #1;
                if (bus.cs_pin) break;
                if (k >= 8) begin
`ifdef SPI_MASTER_MISO_SYNC_EN
                    repeat (2) @(posedge clk);
`endif
                    bus.miso_pin = slave_data[15-k];
                end
            end
        end
    end

    int         cyc = 0, fall_cyc = 0, rise_cyc = -1000, nrise = 0, busy_low = 0;
    logic       in_frame = 1'b0, await_bfall = 1'b0;
    logic       p_sclk = 1'b0, p_cs = 1'b1, p_done = 1'b0, p_busy = 1'b0;
    logic [15:0] cap = 16'h0;
    logic [7:0] rd_model = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset_n) begin
            in_frame    = 1'b0;
            await_bfall = 1'b0;
            sb_q.delete();
            rd_model    = 8'h00;
        end else begin
            if (p_cs && !bus.cs_pin) begin
                in_frame = 1'b1;
                fall_cyc = cyc;
                nrise    = 0;
                busy_low = 0;
                cap      = 16'h0;
                if (b2b_chk) check("b2b_cs_gap", 32'(cyc - rise_cyc), CLKDIV + 1);
            end
            if (in_frame && !p_sclk && bus.sclk_pin) begin
                cap = {cap[14:0], bus.mosi_pin};
                nrise++;
            end
            if (in_frame && !bus.busy) busy_low++;
            if (await_bfall && p_busy && !bus.busy) begin
                check("busy_fall_delay", 32'(cyc - rise_cyc), CLKDIV);
                await_bfall = 1'b0;
            end
            if (bus.done) begin
                done_cnt++;
                check("done_width", 32'(p_done), 0);
                check("done_expected", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("mosi_frame", 32'(cap), 32'(e.frame));
                    check("sclk_rises", 32'(nrise), 16);
                    check("cs_low_cycles", 32'(cyc - fall_cyc), 33 * CLKDIV);
                    check("cs_rise_at_done", {30'd0, p_cs, bus.cs_pin}, 32'd1);
                    check("busy_in_frame", 32'(busy_low), 0);
                    if (e.is_read) rd_model = e.rdata;
                    check("rdata", 32'(bus.rdata), 32'(rd_model));
                end
                in_frame    = 1'b0;
                rise_cyc    = cyc;
                await_bfall = 1'b1;
            end
        end
        p_sclk = bus.sclk_pin;
        p_cs   = bus.cs_pin;
        p_done = bus.done;
        p_busy = bus.busy;
    end

    task automatic push_exp(input logic r, input logic [6:0] a, input logic [7:0] w,
                            input logic [7:0] rd);
        exp_t e;
        e.frame   = {a, r, (r ? 8'h00 : w)};
        e.is_read = r;
        e.rdata   = rd;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] w,
                         input logic [7:0] rd);
        push_exp(r, a, w, rd);
        slave_data = rd;
        bus.rw     = r;
        bus.addr   = a;
        bus.wdata  = w;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(bus.busy), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, n, r;
        logic p;
        bus.start = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = 7'h00;
        bus.wdata = 8'h00;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 32'(bus.cs_pin), 1);
        check("rst_sclk", 32'(bus.sclk_pin), 0);
        check("rst_mosi", 32'(bus.mosi_pin), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_rdata", 32'(bus.rdata), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        issue(1'b0, 7'h15, 8'hA5, 8'h00);
        wait_idle("t1_idle");

        // Abort a write right after the 6th sclk rise.
        d0 = done_cnt;
        issue(1'b0, 7'h2A, 8'h3C, 8'h00);
        r = 0; n = 0; p = 1'b0;
        while (r < 6 && n < 200) begin
            @(posedge clk); #1;
            if (bus.sclk_pin && !p) r++;
            p = bus.sclk_pin;
            n++;
        end
        check("t2_edge6_reached", 32'(r), 6);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("t2_abort_cs", 32'(bus.cs_pin), 1);
        check("t2_abort_sclk", 32'(bus.sclk_pin), 0);
        check("t2_abort_busy", 32'(bus.busy), 0);
        check("t2_abort_done", 32'(bus.done), 0);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t2_no_done", 32'(done_cnt - d0), 0);

        issue(1'b0, 7'h7F, 8'h01, 8'h00);
        wait_idle("t3_idle");

        issue(1'b1, 7'h15, 8'h00, 8'h5A);
        wait_idle("t4_idle");

        // A start pulse mid-transaction must be dropped, not queued.
        d0 = done_cnt;
        issue(1'b0, 7'h33, 8'hF0, 8'h5A);
        repeat (19) @(posedge clk);
        #1;
        bus.rw = 1'b1; bus.addr = 7'h01; bus.wdata = 8'hFF; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle("t5_idle");
        repeat (20) @(posedge clk);
        #1;
        check("t5_not_queued", 32'(bus.busy), 0);
        check("t5_one_done", 32'(done_cnt - d0), 1);

        // Back-to-back: start held high across the first transaction's end.
        d0 = done_cnt;
        push_exp(1'b0, 7'h41, 8'h96, 8'h81);
        push_exp(1'b1, 7'h0C, 8'hEE, 8'h81);
        bus.rw = 1'b0; bus.addr = 7'h41; bus.wdata = 8'h96; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.rw = 1'b1; bus.addr = 7'h0C; bus.wdata = 8'hEE; slave_data = 8'h81;
        n = 0;
        while (bus.cs_pin && n < 50) begin @(posedge clk); #1; n++; end
        @(negedge clk); #1;
        b2b_chk = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 400) begin @(posedge clk); #1; n++; end
        n = 0;
        while (bus.busy && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("t6_second_accepted", 32'(bus.busy), 1);
        wait_idle("t6_idle");
        b2b_chk = 1'b0;
        check("t6_two_dones", 32'(done_cnt - d0), 2);

        issue(1'b1, 7'h6E, 8'h00, 8'hC3);
        wait_idle("t7_idle");
        check("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
